instr_encoder: RTL and testbench

- Writer-side counterpart to the CPU's opcode decode. It accepts instruction fields over a valid/ready handshake.
- It classifies the opcode with the same rules the decoder uses and packs the fields into a 32-bit R/I/JI/JII word.
- It writes each word into instruction memory at an auto-incrementing address.
- Used by the board controller to load programs into imem at runtime.

---
 rtl/isa_pkg.sv | 39 +++
 rtl/instr_packer.sv | 42 ++++
 rtl/instr_encoder.sv | 170 +++++++++++++++++
 tb/tb_instr_encoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Opcode constants, field positions and format classification shared by the
// instruction packer, the encoder FSM and any assembler-side reference model.
package isa_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 27;
  localparam int RD_MSB    = 26;
  localparam int RD_LSB    = 22;
  localparam int RS_MSB    = 21;
  localparam int RS_LSB    = 17;
  localparam int RT_MSB    = 16;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_MSB = 11;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_MSB = 6;
  localparam int ALUOP_LSB = 2;
  localparam int IMM_MSB   = 16;
  localparam int IMM_LSB   = 0;
  localparam int TGT_MSB   = 26;
  localparam int TGT_LSB   = 0;

  localparam int signed IMM_MIN = -65536;
  localparam int signed IMM_MAX = 65535;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_JI, FMT_JII} fmt_e;

  // Mirrors the CPU decoder exactly; anything unrecognised is a JI word.
  function automatic fmt_e classify(input logic [4:0] op);
    if (op == OP_RTYPE)                 return FMT_R;
    else if (op[2] & ~op[1] & op[0])    return FMT_I;
    else if (op == OP_JR)               return FMT_JII;
    else                                return FMT_JI;
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: classifies an opcode and assembles the 32-bit word.
// imm_ok_o is the raw 17-bit signed range test; callers qualify it by format.
module instr_packer
  import isa_pkg::*;
(
  input  logic [4:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  shamt_i,
  input  logic [4:0]  aluop_i,
  input  logic [31:0] imm_i,
  input  logic [26:0] target_i,
  output logic [31:0] word_o,
  output fmt_e        fmt_o,
  output logic        imm_ok_o
);

  always_comb begin
    word_o   = '0;
    fmt_o    = classify(opcode_i);
    imm_ok_o = ($signed(imm_i) >= IMM_MIN) && ($signed(imm_i) <= IMM_MAX);
    word_o[OP_MSB:OP_LSB] = opcode_i;
    case (fmt_o)
      FMT_R: begin
        word_o[RD_MSB:RD_LSB]       = rd_i;
        word_o[RS_MSB:RS_LSB]       = rs_i;
        word_o[RT_MSB:RT_LSB]       = rt_i;
        word_o[SHAMT_MSB:SHAMT_LSB] = shamt_i;
        word_o[ALUOP_MSB:ALUOP_LSB] = aluop_i;
      end
      FMT_I: begin
        word_o[RD_MSB:RD_LSB]   = rd_i;
        word_o[RS_MSB:RS_LSB]   = rs_i;
        word_o[IMM_MSB:IMM_LSB] = imm_i[16:0];
      end
      FMT_JII: word_o[RD_MSB:RD_LSB]   = rd_i;
      default: word_o[TGT_MSB:TGT_LSB] = target_i;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Loads instruction words into imem: accepts a field bundle, packs it, and
// writes it at an auto-incrementing address (IDLE -> PACK -> WRITE).
module instr_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            shamt,
  input  logic [4:0]            aluop,
  input  logic [31:0]           imm,
  input  logic [26:0]           target,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_data,
  output logic                  err_range,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [4:0]            op_q, op_d, rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [4:0]            shamt_q, shamt_d, aluop_q, aluop_d;
  logic [31:0]           imm_q, imm_d;
  logic [26:0]           target_q, target_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d, wren_q, wren_d, err_q, err_d;
  logic [31:0]           wdata_q, wdata_d;

  logic [31:0] pk_word;
  fmt_e        pk_fmt;
  logic        pk_imm_ok;
  logic        pk_drop;

  instr_packer u_packer (
    .opcode_i (op_q),
    .rd_i     (rd_q),
    .rs_i     (rs_q),
    .rt_i     (rt_q),
    .shamt_i  (shamt_q),
    .aluop_i  (aluop_q),
    .imm_i    (imm_q),
    .target_i (target_q),
    .word_o   (pk_word),
    .fmt_o    (pk_fmt),
    .imm_ok_o (pk_imm_ok)
  );

  assign pk_drop  = (pk_fmt == FMT_I) & ~pk_imm_ok;
  // Gated by reset_n so the board controller never sees ready while held in reset.
  assign in_ready = reset_n & (state_q == ST_IDLE) & ~full_q & ~start;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    shamt_d  = shamt_q;
    aluop_d  = aluop_q;
    imm_d    = imm_q;
    target_d = target_q;
    addr_d   = addr_q;
    count_d  = count_q;
    full_d   = full_q;
    wren_d   = wren_q;
    err_d    = err_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = '0;
          count_d = '0;
          full_d  = 1'b0;
        end else if (in_valid && in_ready) begin
          op_d     = opcode;
          rd_d     = rd;
          rs_d     = rs;
          rt_d     = rt;
          shamt_d  = shamt;
          aluop_d  = aluop;
          imm_d    = imm;
          target_d = target;
          state_d  = ST_PACK;
        end
      end
      // Output registers are loaded here so the strobe is clean during WRITE.
      ST_PACK: begin
        wren_d  = ~pk_drop;
        err_d   = pk_drop;
        if (!pk_drop) begin
          waddr_d = addr_q;
          wdata_d = pk_word;
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wren_d = 1'b0;
        err_d  = 1'b0;
        if (wren_q) begin
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (addr_q == {ADDR_WIDTH{1'b1}}) full_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      shamt_q  <= '0;
      aluop_q  <= '0;
      imm_q    <= '0;
      target_q <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      wren_q   <= 1'b0;
      err_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      shamt_q  <= shamt_d;
      aluop_q  <= aluop_d;
      imm_q    <= imm_d;
      target_q <= target_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      wren_q   <= wren_d;
      err_q    <= err_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign imem_wren = wren_q;
  assign imem_addr = waddr_q;
  assign imem_data = wdata_q;
  assign err_range = err_q;
  assign full      = full_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a driver predicts each write from the
// encoding rules, and a monitor checks every strobe/error pulse against the queue.
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    opcode = '0, rd = '0, rs = '0, rt = '0, shamt = '0, aluop = '0;
  logic [31:0]   imm = '0;
  logic [26:0]   target = '0;
  logic          imem_wren;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          err_range;
  logic          full;
  logic [AW:0]   count;

  typedef struct {
    logic [4:0]  op, rd, rs, rt, shamt, aluop;
    logic [31:0] imm;
    logic [26:0] target;
  } bundle_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          err;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int addr_m = 0;
  int count_m = 0;
  bit full_m = 0;
  int busy = 0;
  bit accepted;

  instr_encoder #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .shamt(shamt), .aluop(aluop), .imm(imm), .target(target),
    .imem_wren(imem_wren), .imem_addr(imem_addr), .imem_data(imem_data),
    .err_range(err_range), .full(full), .count(count)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference encoding by plain arithmetic on field values.
  function automatic longint ref_word(input bundle_t b, output bit ok);
    longint w;
    longint s;
    ok = 1;
    w = longint'(b.op) * (64'd1 << 27);
    if (b.op == 0) begin
      w += longint'(b.rd) * (1 << 22) + longint'(b.rs) * (1 << 17) + longint'(b.rt) * (1 << 12)
         + longint'(b.shamt) * (1 << 7) + longint'(b.aluop) * 4;
    end else if ((b.op % 8) == 5) begin
      s  = longint'($signed(b.imm));
      ok = (s >= -65536) && (s <= 65535);
      w += longint'(b.rd) * (1 << 22) + longint'(b.rs) * (1 << 17) + (s & 64'h1FFFF);
    end else if (b.op == 4) begin
      w += longint'(b.rd) * (1 << 22);
    end else begin
      w += longint'(b.target);
    end
    return w;
  endfunction

  // One driver cycle: present inputs, check ready/full/count, advance the model.
  task automatic step(input bit v, input bit st, input bundle_t b,
                      input bit use_const, input logic [31:0] const_word);
    bit exp_ready;
    bit ok;
    longint w;
    exp_t e;
    @(negedge clock);
    in_valid = v; start = st;
    opcode = b.op; rd = b.rd; rs = b.rs; rt = b.rt; shamt = b.shamt; aluop = b.aluop;
    imm = b.imm; target = b.target;
    #1;
    accepted  = 0;
    exp_ready = (busy == 0) && !full_m && !st;
    chk("in_ready", in_ready, exp_ready);
    if (busy == 0) begin
      chk("full", full, full_m);
      chk("count", count, count_m);
    end
    if (busy == 0 && st) begin
      addr_m = 0; count_m = 0; full_m = 0;
    end else if (v && exp_ready) begin
      w = ref_word(b, ok);
      e.addr = addr_m; e.data = use_const ? const_word : w[31:0];
      e.err = !ok; e.cnt = count_m;
      sb.push_back(e);
      if (ok) begin
        if (addr_m == DEPTH - 1) full_m = 1;
        addr_m = (addr_m + 1) % DEPTH;
        count_m++;
      end
      busy = 2;
      accepted = 1;
    end else if (busy > 0) begin
      busy--;
    end
    $display("cyc v=%0b st=%0b op=%02h acc=%0b addr_m=%0d cnt_m=%0d full_m=%0b",
             v, st, b.op, accepted, addr_m, count_m, full_m);
  endtask

  task automatic send(input bundle_t b, input bit use_const, input logic [31:0] cw);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, b, use_const, cw);
      if (accepted) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bundle_t z;
    z = '{default: '0};
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, z, 1'b0, 32'h0);
  endtask

  function automatic bundle_t mk(input logic [4:0] op, input logic [4:0] rd_v,
                                 input logic [4:0] rs_v, input logic [4:0] rt_v,
                                 input logic [31:0] imm_v, input logic [26:0] tgt);
    bundle_t b;
    b.op = op; b.rd = rd_v; b.rs = rs_v; b.rt = rt_v; b.shamt = 0; b.aluop = 0;
    b.imm = imm_v; b.target = tgt;
    return b;
  endfunction

  function automatic bundle_t rnd_bundle();
    bundle_t b;
    int sel;
    logic [31:0] bnd [4];
    bnd[0] = 32'd65535; bnd[1] = 32'd65536; bnd[2] = -32'sd65536; bnd[3] = -32'sd65537;
    b.op = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 2) == 0) b.op = {2'($urandom_range(0, 3)), 3'b101};
    b.rd = 5'($urandom); b.rs = 5'($urandom); b.rt = 5'($urandom);
    b.shamt = 5'($urandom); b.aluop = 5'($urandom); b.target = 27'($urandom);
    sel = $urandom_range(0, 3);
    if (sel == 0)      b.imm = $urandom;
    else if (sel == 1) b.imm = bnd[$urandom_range(0, 3)];
    else               b.imm = 32'($urandom_range(0, 131071)) - 32'd65536;
    return b;
  endfunction

  // Monitor: every strobe or error pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && (imem_wren || err_range)) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {imem_wren, err_range}, 0);
      end else begin
        e = sb.pop_front();
        chk("err_range", err_range, e.err);
        chk("imem_wren", imem_wren, !e.err);
        if (!e.err) begin
          chk("imem_addr", imem_addr, e.addr);
          chk("imem_data", imem_data, e.data);
        end
        chk("count_at_strobe", count, e.cnt);
        $display("txn addr=%0d data=%08h err=%0b", imem_addr, imem_data, err_range);
      end
    end
  end

  initial begin
    bundle_t b;
    exp_t dropped;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wren", imem_wren, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_data", imem_data, 0);
    chk("rst_err", err_range, 0);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    @(negedge clock); reset_n = 1;

    b = mk(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 27'd0);
    send(b, 1'b1, 32'h00C22000);
    b = mk(5'b00101, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 27'd0);
    send(b, 1'b1, 32'h2941FFFF);
    b = mk(5'b00101, 5'd5, 5'd0, 5'd0, 32'd70000, 27'd0);
    send(b, 1'b0, 32'h0);
    b = mk(5'b00100, 5'd31, 5'd9, 5'd17, 32'd1234, 27'h7FF);
    send(b, 1'b1, 32'h27C00000);
    b = mk(5'b10110, 5'd7, 5'd7, 5'd7, 32'd0, 27'h123);
    send(b, 1'b1, 32'hB0000123);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b, 1'b0, 32'h0);

    // start together with valid: rewind, no handshake; then accepted next cycle.
    step(1'b1, 1'b1, b, 1'b0, 32'h0);
    chk("start_no_hs", accepted, 0);
    send(b, 1'b1, 32'hB0000123);
    idle(3);

    // Reset asserted while the bundle sits in PACK.
    b = mk(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 27'd0);
    send(b, 1'b0, 32'h0);
    @(negedge clock);
    in_valid = 0; reset_n = 0;
    #1;
    chk("midrst_wren", imem_wren, 0);
    chk("midrst_data", imem_data, 0);
    chk("midrst_count", count, 0);
    chk("midrst_in_ready", in_ready, 0);
    dropped = sb.pop_back();
    addr_m = 0; count_m = 0; full_m = 0; busy = 0;
    @(negedge clock); reset_n = 1;
    idle(3);
    send(mk(5'b00101, 5'd4, 5'd6, 5'd0, 32'd42, 27'd0), 1'b0, 32'h0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rnd_bundle(), 1'b0, 32'h0);
    end
    in_valid = 0; start = 0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
